// File: rtl/sobel_edge_overlay.sv
// sobel_edge_overlay: binarizes the Sobel magnitude against a manual or
// frame-adaptive threshold and emits an RGB565 pixel (binary or colour overlay).
// Per-frame edge statistics drive a once-per-frame auto-threshold step.
// Optional macro SOBEL_EDGE_HYST_EN enables scan-line hysteresis on the hit decision.
module sobel_edge_overlay #(
  parameter logic [7:0]  THR_INIT   = 8'd32,
  parameter logic [7:0]  THR_MIN    = 8'd4,
  parameter logic [7:0]  THR_STEP   = 8'd2,
  parameter logic [16:0] TARGET_LO  = 17'd3000,
  parameter logic [16:0] TARGET_HI  = 17'd9000,
  parameter logic [15:0] EDGE_COLOR = 16'hF800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  edge_in,
  input  logic        edge_valid,
  input  logic [15:0] rgb_in,
  input  logic        vsync,
  input  logic        auto_mode,
  input  logic [7:0]  thr_manual,
  input  logic        overlay_en,
  output logic [15:0] rgb_out,
  output logic        out_valid,
  output logic        edge_bit,
  output logic [16:0] edge_count,
  output logic [7:0]  thr_cur,
  output logic        frame_done
);

  typedef enum logic [1:0] {StIdle, StEval, StUpdate} state_e;

  state_e      state_q, state_d;
  logic [7:0]  edge_s1;
  logic [15:0] rgb_s1;
  logic        valid_s1;
  logic [7:0]  thr_reg;
  logic [16:0] run_cnt, cnt_next, snapshot;
  logic        vsync_prev, vsync_rise;
  logic        hit_raw, hit_s2;
  logic        dec_up, dec_dn;
  logic        eval_en, upd_en;
  logic [8:0]  thr_up9, thr_dn9;
  logic [7:0]  thr_up, thr_dn;

  assign thr_cur    = auto_mode ? thr_reg : thr_manual;
  assign vsync_rise = vsync & ~vsync_prev;

`ifdef SOBEL_EDGE_HYST_EN
  logic prev_hit;
  assign hit_raw = (edge_s1 >= thr_cur) | (prev_hit & (edge_s1 >= {1'b0, thr_cur[7:1]}));

  // Previous accepted pixel's decision; restarts each frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          prev_hit <= 1'b0;
    else if (vsync_rise) prev_hit <= 1'b0;
    else if (valid_s1)   prev_hit <= hit_raw;
  end
`else
  assign hit_raw = (edge_s1 >= thr_cur);
`endif

  assign hit_s2 = valid_s1 & hit_raw;

  // Stage 1: capture accepted pixels; idle cycles propagate valid=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_s1  <= 8'd0;
      rgb_s1   <= 16'd0;
      valid_s1 <= 1'b0;
    end else begin
      valid_s1 <= enable & edge_valid;
      if (enable & edge_valid) begin
        edge_s1 <= edge_in;
        rgb_s1  <= rgb_in;
      end
    end
  end

  // Stage 2: threshold decision and pixel formatting; rgb_out holds on bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_out   <= 16'd0;
      out_valid <= 1'b0;
      edge_bit  <= 1'b0;
    end else begin
      out_valid <= valid_s1;
      edge_bit  <= hit_s2;
      if (valid_s1) begin
        if (overlay_en) rgb_out <= hit_raw ? EDGE_COLOR : rgb_s1;
        else            rgb_out <= hit_raw ? 16'hFFFF : 16'h0000;
      end
    end
  end

  // Saturating increment; a hit coincident with vsync belongs to the old frame.
  assign cnt_next = (run_cnt == 17'h1FFFF) ? run_cnt : run_cnt + {16'd0, hit_s2};

  // Running edge counter, frame snapshot and vsync edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt    <= 17'd0;
      snapshot   <= 17'd0;
      vsync_prev <= 1'b0;
    end else begin
      vsync_prev <= vsync;
      if (vsync_rise) begin
        snapshot <= cnt_next;
        run_cnt  <= 17'd0;
      end else begin
        run_cnt  <= cnt_next;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state; a new frame edge always restarts evaluation.
  always_comb begin
    state_d = state_q;
    if (vsync_rise) begin
      state_d = StEval;
    end else begin
      unique case (state_q)
        StIdle:   state_d = StIdle;
        StEval:   state_d = StUpdate;
        StUpdate: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // FSM outputs; the update is dropped if a new frame edge arrives.
  always_comb begin
    frame_done = 1'b0;
    eval_en    = 1'b0;
    upd_en     = 1'b0;
    unique case (state_q)
      StIdle:   ;
      StEval:   begin frame_done = 1'b1; eval_en = 1'b1; end
      StUpdate: upd_en = ~vsync_rise;
      default:  ;
    endcase
  end

  // Saturated threshold steps computed in 9 bits so they never wrap.
  assign thr_up9 = {1'b0, thr_reg} + {1'b0, THR_STEP};
  assign thr_dn9 = {1'b0, thr_reg} - {1'b0, THR_STEP};
  assign thr_up  = thr_up9[8] ? 8'd255 : thr_up9[7:0];
  assign thr_dn  = ({1'b0, thr_reg} >= ({1'b0, THR_MIN} + {1'b0, THR_STEP}))
                   ? thr_dn9[7:0] : THR_MIN;

  // Frame statistics, step decision and threshold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_count <= 17'd0;
      dec_up     <= 1'b0;
      dec_dn     <= 1'b0;
      thr_reg    <= THR_INIT;
    end else begin
      if (eval_en) begin
        edge_count <= snapshot;
        dec_up     <= (snapshot > TARGET_HI);
        dec_dn     <= (snapshot < TARGET_LO);
      end
      if (!auto_mode) begin
        thr_reg <= thr_manual;
      end else if (upd_en) begin
        if (dec_up)      thr_reg <= thr_up;
        else if (dec_dn) thr_reg <= thr_dn;
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_overlay.sv
// Scoreboard bench for sobel_edge_overlay: stimulus pushes expected pixels and
// frame counts into queues; monitor processes pop and compare on DUT strobes.
module tb_sobel_edge_overlay;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  edge_in = 8'd0;
  logic        edge_valid = 1'b0;
  logic [15:0] rgb_in = 16'd0;
  logic        vsync = 1'b0;
  logic        auto_mode = 1'b0;
  logic [7:0]  thr_manual = 8'd32;
  logic        overlay_en = 1'b0;
  logic [15:0] rgb_out;
  logic        out_valid;
  logic        edge_bit;
  logic [16:0] edge_count;
  logic [7:0]  thr_cur;
  logic        frame_done;

  sobel_edge_overlay dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .edge_in    (edge_in),
    .edge_valid (edge_valid),
    .rgb_in     (rgb_in),
    .vsync      (vsync),
    .auto_mode  (auto_mode),
    .thr_manual (thr_manual),
    .overlay_en (overlay_en),
    .rgb_out    (rgb_out),
    .out_valid  (out_valid),
    .edge_bit   (edge_bit),
    .edge_count (edge_count),
    .thr_cur    (thr_cur),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rgb;
    logic        bit_e;
    int          cyc;
  } pix_t;

  pix_t        sb_q[$];
  int          frame_q[$];
  int          cyc = 0;
  int          n_total = 0;
  int          n_pass = 0;
  int          model_cnt = 0;
  logic        cnt_pending = 1'b0;
  int          cnt_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Pixel monitor and frame monitor.
  always @(negedge clk) begin
    if (cnt_pending) begin
      check("edge_count", {15'd0, edge_count}, cnt_exp);
      cnt_pending = 1'b0;
    end
    if (frame_done) begin
      check("frame_done_expected", {31'd0, frame_q.size() != 0}, 32'd1);
      if (frame_q.size() != 0) begin
        cnt_exp = frame_q.pop_front();
        cnt_pending = 1'b1;
      end
    end
    if (out_valid) begin
      check("out_valid_expected", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        pix_t p;
        p = sb_q.pop_front();
        check("rgb_out", {16'd0, rgb_out}, {16'd0, p.rgb});
        check("edge_bit", {31'd0, edge_bit}, {31'd0, p.bit_e});
        check("latency", cyc, p.cyc);
      end
    end
  end

  task automatic send(input logic [7:0] e, input logic [15:0] rgb,
                      input logic exp_bit, input logic [15:0] exp_rgb);
    pix_t p;
    edge_in = e;
    rgb_in = rgb;
    edge_valid = 1'b1;
    enable = 1'b1;
    p.rgb = exp_rgb;
    p.bit_e = exp_bit;
    p.cyc = cyc + 2;
    sb_q.push_back(p);
    if (exp_bit) model_cnt++;
    @(posedge clk); #1;
    edge_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Raises vsync now; returns once the update cycle has completed.
  task automatic pulse_vsync();
    frame_q.push_back(model_cnt);
    model_cnt = 0;
    vsync = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vsync = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) send(8'd255, 16'h1234, 1'b1, 16'hFFFF);
    idle(4);
  endtask

  task automatic start_auto(input logic [7:0] thr);
    auto_mode = 1'b0;
    thr_manual = thr;
    idle(2);
    pulse_vsync();
    idle(2);
    auto_mode = 1'b1;
  endtask

  initial begin
    // Reset state.
    auto_mode = 1'b1;
    #12;
    check("rst_rgb_out", {16'd0, rgb_out}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_edge_count", {15'd0, edge_count}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_thr_cur", {24'd0, thr_cur}, 32'd32);
    @(posedge clk); #1;
    rst_n = 1'b1;
    auto_mode = 1'b0;
    idle(2);

    // Latency and binary output; a non-enabled strobe must be ignored.
    thr_manual = 8'd50;
    overlay_en = 1'b0;
    send(8'd60, 16'h1111, 1'b1, 16'hFFFF);
    send(8'd40, 16'h2222, 1'b0, 16'h0000);
    edge_in = 8'd255; edge_valid = 1'b1; enable = 1'b0;
    @(posedge clk); #1;
    edge_valid = 1'b0; enable = 1'b1;
    idle(4);
    send(8'd50, 16'h3333, 1'b1, 16'hFFFF);
    send(8'd49, 16'h3333, 1'b0, 16'h0000);
    idle(3);

    // Overlay mode.
    overlay_en = 1'b1;
    send(8'd200, 16'h07E0, 1'b1, 16'hF800);
    send(8'd10, 16'h07E0, 1'b0, 16'h07E0);
    idle(3);
    overlay_en = 1'b0;

    // Auto up: 10000 hits at thr 32.
    start_auto(8'd32);
    check("auto_start_thr", {24'd0, thr_cur}, 32'd32);
    hits(10000);
    pulse_vsync();
    check("auto_up_thr", {24'd0, thr_cur}, 32'd34);

    // Auto down with floor saturation.
    start_auto(8'd5);
    hits(100);
    pulse_vsync();
    check("auto_down_thr", {24'd0, thr_cur}, 32'd4);
    hits(100);
    pulse_vsync();
    check("auto_floor_thr", {24'd0, thr_cur}, 32'd4);

    // Ceiling and hold band.
    start_auto(8'd254);
    hits(20000);
    pulse_vsync();
    check("auto_ceil_thr", {24'd0, thr_cur}, 32'd255);
    hits(5000);
    pulse_vsync();
    check("auto_hold_thr", {24'd0, thr_cur}, 32'd255);

    // Hit coincident with the vsync rise counts toward the old frame.
    auto_mode = 1'b0;
    thr_manual = 8'd32;
    idle(2);
    pulse_vsync();
    for (int i = 0; i < 5; i++) send(8'd100, 16'h0, 1'b1, 16'hFFFF);
    idle(3);
    send(8'd100, 16'h0, 1'b1, 16'hFFFF);
    pulse_vsync();
    idle(3);

    // Hysteresis along the scan line.
    thr_manual = 8'd40;
    idle(1);
    pulse_vsync();
    send(8'd50, 16'h0, 1'b1, 16'hFFFF);
`ifdef SOBEL_EDGE_HYST_EN
    send(8'd25, 16'h0, 1'b1, 16'hFFFF);
    send(8'd25, 16'h0, 1'b1, 16'hFFFF);
`else
    send(8'd25, 16'h0, 1'b0, 16'h0000);
    send(8'd25, 16'h0, 1'b0, 16'h0000);
`endif
    send(8'd15, 16'h0, 1'b0, 16'h0000);
    idle(4);

    // Mid-frame reset, then a partial frame in auto mode.
    for (int i = 0; i < 3; i++) send(8'd100, 16'h0, 1'b1, 16'hFFFF);
    idle(4);
    auto_mode = 1'b1;
    rst_n = 1'b0;
    model_cnt = 0;
    #1;
    check("mid_rst_rgb_out", {16'd0, rgb_out}, 32'd0);
    check("mid_rst_edge_count", {15'd0, edge_count}, 32'd0);
    check("mid_rst_thr_cur", {24'd0, thr_cur}, 32'd32);
    check("mid_rst_edge_bit", {31'd0, edge_bit}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    hits(7);
    pulse_vsync();
    check("partial_down_thr", {24'd0, thr_cur}, 32'd30);

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && (sb_q.size() != 0 || frame_q.size() != 0); i++) idle(1);
    idle(2);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    check("frames_drained", frame_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sobel_edge_overlay.md
Name: sobel_edge_overlay

Overview:
- Downstream consumer of the 3x3 grayscale Sobel stage. Takes the 8-bit edge magnitude and its ready strobe, binarizes it against a manual or frame-adaptive threshold, and emits an RGB565 pixel for the VGA path.
- Output is either binary black/white or the camera pixel with edge pixels painted in a fixed colour.
- Keeps per-frame edge statistics and, in auto mode, steps the threshold once per frame toward a target edge density.

Parameters:
- THR_INIT, 8'd32, threshold loaded at reset.
- THR_MIN, 8'd4, lower saturation bound for the auto threshold.
- THR_STEP, 8'd2, auto-mode increment/decrement per frame.
- TARGET_LO, 17'd3000, edge count below which the threshold is lowered.
- TARGET_HI, 17'd9000, edge count above which the threshold is raised.
- EDGE_COLOR, 16'hF800, RGB565 colour painted on edge pixels in overlay mode.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  pixel clock-enable; same strobe as the Sobel stage.
- edge_in  in  8  Sobel magnitude.
- edge_valid  in  1  Sobel ready strobe; edge_in is valid when high.
- rgb_in  in  16  camera RGB565 pixel, already aligned with edge_in.
- vsync  in  1  frame sync; the rising edge marks frame start.
- auto_mode  in  1  1 = adaptive threshold, 0 = thr_manual.
- thr_manual  in  8  manual threshold.
- overlay_en  in  1  1 = colour overlay, 0 = binary output.
- rgb_out  out  16  output pixel.
- out_valid  out  1  rgb_out valid.
- edge_bit  out  1  binarized edge decision aligned with rgb_out.
- edge_count  out  17  edge pixels counted in the previous frame.
- thr_cur  out  8  threshold currently applied.
- frame_done  out  1  one-cycle pulse when edge_count is updated.

Behaviour:
- Reset values: rgb_out=0, out_valid=0, edge_bit=0, edge_count=0, frame_done=0, thr_reg=THR_INIT, running counter=0, FSM=IDLE, vsync_prev=0.
- Pipeline: 2 registers. Only cycles with enable=1 and edge_valid=1 are accepted.
  - S1 registers edge_in, rgb_in and valid.
  - S2 computes hit = (edge_in_s1 >= thr_cur).
  - S2 output for binary mode: rgb_out = hit ? 16'hFFFF : 16'h0000.
  - S2 output for overlay mode: rgb_out = hit ? EDGE_COLOR : rgb_in_s1.
  - S2 also drives edge_bit = hit and out_valid = valid_s1.
- Latency: accepted input at cycle N produces out_valid=1 at N+2. Non-accepted cycles propagate valid=0; in that case rgb_out holds its last value and edge_bit=0.
- thr_cur source: equals thr_manual when auto_mode=0, else thr_reg. Both are sampled at S2.
- Mode switch: while auto_mode=0, thr_reg tracks thr_manual every cycle, so switching to auto starts from the manual value.
- Edge counter: 17-bit running counter, +1 per S2 hit, saturating at 17'h1FFFF.
- Frame boundary: vsync rising edge is detected with vsync_prev.
  - Latch running counter (including a hit in the same cycle) into snapshot.
  - Clear the running counter; a hit arriving in the same cycle counts toward the old frame.
  - Go to EVAL.
- FSM IDLE -> EVAL -> UPDATE -> IDLE:
  - EVAL: edge_count <= snapshot; frame_done=1 for this cycle; decision = up if snapshot > TARGET_HI, down if snapshot < TARGET_LO, else hold.
  - UPDATE (auto_mode=1 only): up gives thr_reg = min(255, thr_reg+THR_STEP); down gives thr_reg = max(THR_MIN, thr_reg-THR_STEP). Use 9-bit intermediate arithmetic, no wrap.
  - A vsync rising edge while in EVAL/UPDATE restarts EVAL with a new snapshot, and the pending update is dropped.
- Threshold updates land between frames; the pixel pipeline never stalls.
- rst_n asserted mid-frame clears everything immediately; the first frame after release reports a partial count.

Optional Feature:
- Macro: SOBEL_EDGE_HYST_EN.
- Defined: hysteresis along the scan line.
  - hit = (edge_in_s1 >= thr_cur) OR (prev_hit AND edge_in_s1 >= thr_cur>>1).
  - prev_hit is the previous accepted pixel's hit; it is cleared on vsync rising edge and on reset.
- Undefined: single threshold only; no prev_hit register is synthesized.

Test Plan:
- Latency: auto_mode=0, thr_manual=50, overlay_en=0. Drive edge_in=60 then 40 with edge_valid=1 → rgb_out=FFFF then 0000 at +2 cycles; out_valid high exactly 2 cycles.
- Overlay: overlay_en=1, rgb_in=16'h07E0, edge_in=200 then 10 → rgb_out=F800 then 07E0.
- Auto up: auto_mode=1, thr_reg=32, frame of 10000 hits, vsync rise → frame_done pulse, edge_count=10000, thr_cur=34 two cycles later.
- Auto down and saturation: thr_reg=5, frame of 100 hits → thr_cur=4. Repeat → stays 4.
- Ceiling and hold: thr_reg=254 with 20000 hits → 255. A frame of 5000 hits → unchanged.
- Mid-operation events: vsync rise coincident with a hit → old frame count includes it. rst_n pulse mid-frame → all outputs 0, thr_cur=THR_INIT. With SOBEL_EDGE_HYST_EN: thr=40, sequence 50,25,25,15 → edge_bit 1,1,1,0.
